fir_transposed_param: RTL and testbench
=======================================

Name: fir_transposed_param

Overview:
Parametrised transposed-form FIR filter, the successor to the fixed 41-tap hard-coded-coefficient MAC chain. Tap count, data, coefficient, accumulator and output widths are parameters. Coefficients are run-time loadable through a double-buffered shadow bank. Input valid gates the pipeline, and an output valid is produced. Sits between the sample source and downstream DSP in the 100 MHz domain.

Parameters:
TAPS, 41, number of filter taps (>=2)
DATA_W, 17, signed input sample width
COEF_W, 17, signed coefficient width
ACC_W, 35, accumulator/partial-sum width (>= DATA_W+COEF_W+1)
OUT_SHIFT, 14, LSB index of the accumulator slice driven to y_data
OUT_W, 17, signed output width (OUT_SHIFT+OUT_W <= ACC_W)

Ports:
clk_100MHz  in  1  sole clock, all logic rising-edge
reset  in  1  synchronous, active-high
x  in  DATA_W  signed input sample
x_valid  in  1  sample strobe; pipeline advances only when high
flush  in  1  clear partial sums z[1..TAPS-1]; coefficients untouched
coef_wr_en  in  1  write coef_data to shadow[coef_addr]
coef_addr  in  $clog2(TAPS)  shadow coefficient index
coef_data  in  COEF_W  signed coefficient value
coef_commit  in  1  pulse: copy whole shadow bank to active bank
y_data  out  OUT_W  filtered output
y_valid  out  1  one-cycle strobe, y_data updated

Behaviour:
- Reset (sync, highest priority): z[*]=0, active[*]=0, shadow[*]=0, y_data=0, y_valid=0. Reset mid-stream discards all history; the first post-reset output uses zero history.
- Filter: y[n] = sum_k active[k]*x[n-k], k=0..TAPS-1, in transposed form. On a cycle with x_valid=1:
  - z[TAPS-1] <= x*active[TAPS-1]
  - z[k] <= x*active[k] + z[k+1], for 1<=k<TAPS-1
  - acc = x*active[0] + z[1]
- Arithmetic: product DATA_W+COEF_W signed, sign-extended to ACC_W. Sums wrap modulo 2^ACC_W with no internal saturation.
- Latency: y_valid=1 exactly one cycle after an x_valid=1 cycle, else 0. y_data = acc[OUT_SHIFT+OUT_W-1:OUT_SHIFT] (truncation, no rounding). y_data holds its value between strobes.
- x_valid=0: z[*], y_data hold; y_valid=0. Gaps of any length are sample-transparent.
- flush=1: z[1..TAPS-1] <= 0. If x_valid is also high in the same cycle, flush wins: no outputs are produced and y_valid=0 next cycle.
- Coefficient write: on coef_wr_en=1, shadow[coef_addr] <= coef_data. Writes with coef_addr >= TAPS are ignored. The active bank is never written directly.
- Commit: on coef_commit=1, active <= shadow at the clock edge. A sample in the same cycle as the commit uses the OLD active set; the new set applies from the next sample. Partial sums are not cleared, so the transition is mixed.
- coef_wr_en and coef_commit in the same cycle: the commit copies the pre-write shadow value; the written value lands in shadow only.
- Fully synchronous, single clock, no combinational input-to-output path.

Optional Feature:
SAT_EN.
- Defined: if acc>>>OUT_SHIFT exceeds the OUT_W signed range, y_data clamps to max (0 followed by ones) or min (1 followed by zeros).
- Undefined: plain bit-slice truncation, which wraps.
- Only y_data differs between the two builds; latency is identical.

Test Plan:
- Defaults. Load the lowpass set h = 5, 8, 8, 2, -13, -40, ..., 1952 (h[20]), ..., 5 (symmetric) and commit. Drive impulse x=16384 then 40 zeros, all valid. -> y_data sequence equals h[0..40] exactly (5, 8, 8, 2, 0x1fff3, ...), one y_valid per sample, 1-cycle latency.
- Same impulse with random 0-3 cycle x_valid gaps. -> Identical y_data sequence; y_valid count = 41; y_data stable during gaps.
- Load h[0..3]=65535, rest 0, commit. Drive x=65535 for 4 valid samples.
  - Sample 4 (acc=17179344900) -> y_data=0x1FFE0 without SAT_EN.
  - Same sample -> y_data=0x0FFFF with SAT_EN.
- Coefficients: with the impulse set active, write shadow (incl. coef_addr=TAPS, which is ignored) and commit on the same cycle as a sample.
  - That sample uses the old set; the following sample uses the new set.
  - The out-of-range write has no effect.
- Assert reset mid-stream (and flush in a separate run), then drive x=16384 once. -> Outputs reflect zero history.
  - After reset: y_data=0, because active coefficients are cleared.
  - After flush: y_data=h[0] with coefficients retained.
- Assert x_valid and flush in the same cycle. -> No y_valid next cycle; z cleared.

Source files
------------

// File: rtl/fir_transposed_param.sv
// rtl/fir_transposed_param.sv - parametrised transposed-form FIR filter with double-buffered run-time coefficients
//
// Optional build macro: SAT_EN
//   defined   : y_data clamps to the OUT_W signed range when acc>>>OUT_SHIFT overflows it
//   undefined : y_data is a plain bit slice of acc (wraps)
//
// Ports:
//   clk_100MHz   sole clock, all logic on the rising edge
//   reset        synchronous, active-high; clears partial sums, both coefficient banks and outputs
//   x            signed input sample (DATA_W)
//   x_valid      sample strobe; the pipeline advances only when high
//   flush        clears partial sums z[1..TAPS-1]; wins over x_valid; coefficients untouched
//   coef_wr_en   write coef_data into shadow[coef_addr]; addresses >= TAPS are ignored
//   coef_addr    shadow coefficient index
//   coef_data    signed coefficient value (COEF_W)
//   coef_commit  copy the whole shadow bank into the active bank
//   y_data       filtered output (OUT_W), holds between strobes
//   y_valid      one-cycle strobe, one cycle after an accepted sample
module fir_transposed_param #(
  parameter int TAPS      = 41,
  parameter int DATA_W    = 17,
  parameter int COEF_W    = 17,
  parameter int ACC_W     = 35,
  parameter int OUT_SHIFT = 14,
  parameter int OUT_W     = 17
) (
  input  logic                      clk_100MHz,
  input  logic                      reset,
  input  logic signed [DATA_W-1:0]  x,
  input  logic                      x_valid,
  input  logic                      flush,
  input  logic                      coef_wr_en,
  input  logic [$clog2(TAPS)-1:0]   coef_addr,
  input  logic signed [COEF_W-1:0]  coef_data,
  input  logic                      coef_commit,
  output logic signed [OUT_W-1:0]   y_data,
  output logic                      y_valid
);

  localparam int AW = $clog2(TAPS);
  localparam int HI = OUT_SHIFT + OUT_W - 1;

  logic signed [COEF_W-1:0] shadow [TAPS];
  logic signed [COEF_W-1:0] active [TAPS];
  logic signed [ACC_W-1:0]  z      [1:TAPS-1];
  logic signed [ACC_W-1:0]  prod   [TAPS];
  logic signed [ACC_W-1:0]  acc;
  logic signed [OUT_W-1:0]  y_next;
  logic                     addr_ok;
  logic                     unused_acc;

  // Operands are widened to ACC_W before multiplying, so the product is
  // already sign-extended and every later sum wraps modulo 2^ACC_W.
  always_comb begin
    for (int k = 0; k < TAPS; k++) begin
      prod[k] = ACC_W'(x) * ACC_W'(active[k]);
    end
  end

  assign acc        = prod[0] + z[1];
  assign unused_acc = ^acc;

  // Extra leading zero keeps the compare meaningful when TAPS is a power of two.
  assign addr_ok = ({1'b0, coef_addr} < (AW+1)'(TAPS));

`ifdef SAT_EN
  // Bits from the sign bit down to the output MSB must all agree, otherwise
  // the shifted accumulator does not fit in OUT_W signed bits.
  logic [ACC_W-1-HI:0] acc_top;
  assign acc_top = acc[ACC_W-1:HI];

  always_comb begin
    y_next = acc[HI:OUT_SHIFT];
    if (!((&acc_top) || !(|acc_top))) begin
      y_next = acc[ACC_W-1] ? {1'b1, {(OUT_W-1){1'b0}}} : {1'b0, {(OUT_W-1){1'b1}}};
    end
  end
`else
  assign y_next = acc[HI:OUT_SHIFT];
`endif

  // Coefficient banks. The commit reads shadow before this edge's write lands,
  // so a simultaneous write only reaches the shadow bank.
  always_ff @(posedge clk_100MHz) begin
    if (reset) begin
      for (int k = 0; k < TAPS; k++) begin
        shadow[k] <= '0;
        active[k] <= '0;
      end
    end else begin
      if (coef_wr_en && addr_ok) begin
        shadow[coef_addr] <= coef_data;
      end
      if (coef_commit) begin
        for (int k = 0; k < TAPS; k++) begin
          active[k] <= shadow[k];
        end
      end
    end
  end

  // Transposed partial-sum chain and output register. A sample arriving with
  // a commit still multiplies by the pre-commit active bank.
  always_ff @(posedge clk_100MHz) begin
    if (reset) begin
      for (int k = 1; k < TAPS; k++) begin
        z[k] <= '0;
      end
      y_data  <= '0;
      y_valid <= 1'b0;
    end else if (flush) begin
      for (int k = 1; k < TAPS; k++) begin
        z[k] <= '0;
      end
      y_valid <= 1'b0;
    end else if (x_valid) begin
      for (int k = 1; k < TAPS-1; k++) begin
        z[k] <= prod[k] + z[k+1];
      end
      z[TAPS-1] <= prod[TAPS-1];
      y_data    <= y_next;
      y_valid   <= 1'b1;
    end else begin
      y_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fir_transposed_param.sv
// tb/tb_fir_transposed_param.sv - self-checking bench for fir_transposed_param
module tb_fir_transposed_param;

  localparam int TAPS      = 41;
  localparam int DATA_W    = 17;
  localparam int COEF_W    = 17;
  localparam int ACC_W     = 35;
  localparam int OUT_SHIFT = 14;
  localparam int OUT_W     = 17;
  localparam int AW        = $clog2(TAPS);
  localparam int MASK      = (1 << OUT_W) - 1;

  localparam int H [TAPS] = '{
    5, 8, 8, 2, -13, -40, -72, -95, -90, -40, 55, 180, 310, 420, 540, 700, 900, 1150, 1450, 1700,
    1952,
    1700, 1450, 1150, 900, 700, 540, 420, 310, 180, 55, -40, -90, -95, -72, -40, -13, 2, 8, 8, 5
  };

  logic                     clk_100MHz = 1'b0;
  logic                     reset;
  logic signed [DATA_W-1:0] x;
  logic                     x_valid;
  logic                     flush;
  logic                     coef_wr_en;
  logic [AW-1:0]            coef_addr;
  logic signed [COEF_W-1:0] coef_data;
  logic                     coef_commit;
  logic [OUT_W-1:0]         y_data;
  logic                     y_valid;

  int n_vec = 0;
  int n_err = 0;
  bit chk_en = 1'b0;
  int cap [$];

  // Model state: direct-form history, each sample stored with the coefficient
  // set that was active when it arrived.
  longint m_shadow [TAPS];
  longint m_active [TAPS];
  longint hx [TAPS];
  longint hc [TAPS][TAPS];
  bit               exp_valid = 1'b0;
  logic [OUT_W-1:0] exp_y = '0;

  always #5 clk_100MHz = ~clk_100MHz;

  fir_transposed_param #(
    .TAPS(TAPS), .DATA_W(DATA_W), .COEF_W(COEF_W),
    .ACC_W(ACC_W), .OUT_SHIFT(OUT_SHIFT), .OUT_W(OUT_W)
  ) dut (
    .clk_100MHz (clk_100MHz),
    .reset      (reset),
    .x          (x),
    .x_valid    (x_valid),
    .flush      (flush),
    .coef_wr_en (coef_wr_en),
    .coef_addr  (coef_addr),
    .coef_data  (coef_data),
    .coef_commit(coef_commit),
    .y_data     (y_data),
    .y_valid    (y_valid)
  );

  always @(posedge clk_100MHz) begin
    longint acc;
    longint sh;
    longint old_shadow [TAPS];
    if (reset) begin
      for (int k = 0; k < TAPS; k++) begin
        m_shadow[k] = 0;
        m_active[k] = 0;
        hx[k] = 0;
      end
      exp_valid = 1'b0;
      exp_y     = '0;
    end else begin
      old_shadow = m_shadow;
      if (flush) begin
        for (int k = 0; k < TAPS; k++) hx[k] = 0;
        exp_valid = 1'b0;
      end else if (x_valid) begin
        for (int j = TAPS - 1; j > 0; j--) begin
          hx[j] = hx[j-1];
          hc[j] = hc[j-1];
        end
        hx[0] = longint'(x);
        hc[0] = m_active;
        acc = 0;
        for (int k = 0; k < TAPS; k++) acc += hc[k][k] * hx[k];
        acc = acc & ((64'sd1 <<< ACC_W) - 1);
        if (acc[ACC_W-1]) acc = acc - (64'sd1 <<< ACC_W);
        sh = acc >>> OUT_SHIFT;
`ifdef SAT_EN
        if (sh > longint'((1 << (OUT_W-1)) - 1)) sh = longint'((1 << (OUT_W-1)) - 1);
        else if (sh < -longint'(1 << (OUT_W-1))) sh = -longint'(1 << (OUT_W-1));
`endif
        exp_y     = sh[OUT_W-1:0];
        exp_valid = 1'b1;
      end else begin
        exp_valid = 1'b0;
      end
      if (coef_commit) m_active = old_shadow;
      if (coef_wr_en && int'(coef_addr) < TAPS) m_shadow[coef_addr] = longint'(coef_data);
    end
  end

  always @(negedge clk_100MHz) begin
    if (chk_en) begin
      n_vec++;
      if (y_valid !== exp_valid) begin
        n_err++;
        $display("FAIL model_y_valid t=%0t got %0b want %0b", $time, y_valid, exp_valid);
      end
      n_vec++;
      if (y_data !== exp_y) begin
        n_err++;
        $display("FAIL model_y_data t=%0t got %h want %h", $time, y_data, exp_y);
      end
      if (y_valid === 1'b1) cap.push_back(int'(y_data));
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  task automatic check(input string nm, input int act, input int want);
    n_vec++;
    if (act !== want) begin
      n_err++;
      $display("FAIL %s got %0h want %0h", nm, act, want);
    end
  endtask

  task automatic step(input bit v, input int xv, input bit fl, input bit we,
                      input int ad, input int cd, input bit cm, input bit rs);
    x           = DATA_W'(xv);
    x_valid     = v;
    flush       = fl;
    coef_wr_en  = we;
    coef_addr   = AW'(ad);
    coef_data   = COEF_W'(cd);
    coef_commit = cm;
    reset       = rs;
    @(negedge clk_100MHz);
  endtask

  task automatic sample(input int xv);   step(1, xv, 0, 0, 0, 0, 0, 0); endtask
  task automatic idle();                 step(0, 0, 0, 0, 0, 0, 0, 0); endtask
  task automatic wr(input int a, input int d); step(0, 0, 0, 1, a, d, 0, 0); endtask
  task automatic commit();               step(0, 0, 0, 0, 0, 0, 1, 0); endtask
  task automatic do_flush();             step(0, 0, 1, 0, 0, 0, 0, 0); endtask
  task automatic do_reset();             step(0, 0, 0, 0, 0, 0, 0, 1); endtask

  task automatic load_lowpass();
    for (int k = 0; k < TAPS; k++) wr(k, H[k]);
    commit();
    idle();
  endtask

  task automatic check_impulse(input string tag);
    check({tag, "_count"}, cap.size(), TAPS);
    for (int k = 0; k < TAPS && k < cap.size(); k++) begin
      check($sformatf("%s_h%0d", tag, k), cap[k], H[k] & MASK);
    end
  endtask

  initial begin
    x = '0; x_valid = 0; flush = 0; coef_wr_en = 0; coef_addr = '0;
    coef_data = '0; coef_commit = 0; reset = 1;
    @(negedge clk_100MHz);
    do_reset();
    chk_en = 1'b1;
    check("reset_y_valid", int'(y_valid), 0);
    check("reset_y_data", int'(y_data), 0);

    // Impulse through the lowpass set, all samples valid.
    load_lowpass();
    cap.delete();
    sample(16384);
    check("latency_y_valid", int'(y_valid), 1);
    check("latency_y_data", int'(y_data), 5);
    for (int i = 0; i < TAPS - 1; i++) sample(0);
    repeat (3) idle();
    check_impulse("imp");

    // Same impulse with random valid gaps.
    cap.delete();
    for (int i = 0; i < TAPS; i++) begin
      sample(i == 0 ? 16384 : 0);
      repeat ($urandom_range(0, 3)) idle();
    end
    repeat (3) idle();
    check_impulse("gap");

    // Overflow of the output slice.
    for (int k = 0; k < TAPS; k++) wr(k, k < 4 ? 65535 : 0);
    commit();
    do_flush();
    repeat (4) sample(65535);
`ifdef SAT_EN
    check("sat_sample4", int'(y_data), 'h0FFFF);
`else
    check("wrap_sample4", int'(y_data), 'h1FFE0);
`endif
    do_flush();

    // Commit coinciding with a sample; write coinciding with a commit.
    for (int k = 0; k < TAPS; k++) wr(k, k == 0 ? 16384 : 0);
    commit();
    do_flush();
    wr(TAPS, 123);
    wr(0, -16384);
    step(1, 100, 0, 1, 1, 16384, 1, 0);
    check("commit_old_set", int'(y_data), 100);
    sample(100);
    check("commit_new_set", int'(y_data), (-100) & MASK);
    commit();
    sample(100);
    check("wr_commit_pre_write", int'(y_data), (-100) & MASK);
    sample(0);
    check("wr_landed_in_shadow", int'(y_data), 100);

    // Reset mid-stream clears history and coefficients.
    load_lowpass();
    sample(16384); sample(100); sample(-200);
    do_reset();
    sample(16384);
    check("post_reset_y_valid", int'(y_valid), 1);
    check("post_reset_y_data", int'(y_data), 0);

    // Flush mid-stream keeps coefficients.
    load_lowpass();
    sample(16384); sample(300); sample(700);
    do_flush();
    sample(16384);
    check("post_flush_y_data", int'(y_data), 5);

    // Flush and x_valid together: flush wins.
    sample(1000); sample(2000);
    step(1, 5000, 1, 0, 0, 0, 0, 0);
    check("flush_valid_no_strobe", int'(y_valid), 0);
    sample(16384);
    check("flush_valid_cleared_y0", int'(y_data), 5);
    sample(0);
    check("flush_valid_cleared_y1", int'(y_data), 8);
    repeat (3) idle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
